// File: rtl/cc_input_loader.sv
// rtl/cc_input_loader.sv - serial score loader feeding the CC sorter with a held parallel set
// Optional partial-set timeout enabled by defining CC_LOAD_TIMEOUT_EN.
module cc_input_loader #(
  parameter int N_SCORE = 7,
  parameter int SCORE_W = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SCORE_W-1:0]         in_data,
  input  logic [2:0]                 in_opt,
  input  logic [1:0]                 in_a,
  input  logic [2:0]                 in_b,
  output logic [N_SCORE*SCORE_W-1:0] out_scores,
  output logic [2:0]                 out_opt,
  output logic [1:0]                 out_a,
  output logic [2:0]                 out_b,
  output logic                       out_valid,
  input  logic                       out_ack,
  output logic                       load_err
);

  localparam int CNT_W = (N_SCORE > 1) ? $clog2(N_SCORE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             last_beat;
  logic             timeout_hit;

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("cc_input_loader: TIMEOUT must be at least 1");
  end

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign last_beat = (count == CNT_W'(N_SCORE - 1));

`ifdef CC_LOAD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] idle_cnt;

  // Fires on the TIMEOUT-th consecutive idle cycle spent in LOAD.
  assign timeout_hit = (state == LOAD) && !accept && (idle_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
      load_err <= 1'b0;
    end else begin
      load_err <= timeout_hit;
      if ((state != LOAD) || accept || timeout_hit) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign load_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = last_beat ? HOLD : LOAD;
        end
      end
      LOAD: begin
        if (accept && last_beat) begin
          state_next = HOLD;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      HOLD: begin
        if (out_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Slots and config keep their last values after a set is consumed or abandoned.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      out_scores <= '0;
      out_opt    <= '0;
      out_a      <= '0;
      out_b      <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < N_SCORE; i++) begin
          if (count == CNT_W'(i)) begin
            out_scores[i*SCORE_W +: SCORE_W] <= in_data;
          end
        end
        if (state == IDLE) begin
          out_opt <= in_opt;
          out_a   <= in_a;
          out_b   <= in_b;
        end
        count <= last_beat ? '0 : count + 1'b1;
      end else if (timeout_hit) begin
        count <= '0;
      end
    end
  end

endmodule
